// File: rtl/hls_macc_vec.sv
// hls_macc_vec: LANES-wide dot-product multiply-accumulate with an ap_ctrl_hs
// block handshake. One lane is multiplied and summed per cycle through a single
// multiplier; the result can be used fresh (c + dot), accumulated into a
// persistent accumulator, or used to clear that accumulator.
module hls_macc_vec #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   ap_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] a_vec,
  input  logic [LANES*WIDTH-1:0] b_vec,
  input  logic [WIDTH-1:0]       c,
  output logic [WIDTH-1:0]       o1,
  output logic                   o1_ap_vld,
  output logic [WIDTH-1:0]       o2,
  output logic                   o2_ap_vld
);

  // Internal sum width leaves room for every lane product plus a sign bit.
  localparam int SW = 2*WIDTH + $clog2(LANES) + 1;
  localparam int PW = 2*WIDTH;
  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [LANES*WIDTH-1:0]   a_q, a_d;
  logic [LANES*WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]         c_q, c_d;
  logic [1:0]               mode_q, mode_d;
  logic [SW-1:0]            dot_q, dot_d;
  logic [SW-1:0]            acc_q, acc_d;
  logic [WIDTH-1:0]         o1_q, o1_d;
  logic [WIDTH-1:0]         o2_q, o2_d;
  logic                     done_q, done_d;
  logic                     idle_q, idle_d;

  logic [WIDTH-1:0]         a_lane;
  logic [WIDTH-1:0]         b_lane;
  logic [SW-1:0]            acc_sum;

  // Extend a WIDTH-bit operand to the internal sum width.
  function automatic logic [SW-1:0] ext_w(input logic [WIDTH-1:0] x);
    if (SIGNED != 0) return {{(SW-WIDTH){x[WIDTH-1]}}, x};
    else             return {{(SW-WIDTH){1'b0}}, x};
  endfunction

  // A 2*WIDTH product holds any signed or unsigned lane product exactly,
  // so the multiplier stays at 2*WIDTH and only the result is widened.
  function automatic logic [SW-1:0] lane_prod(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    logic [PW-1:0] p;
    xe = (SIGNED != 0) ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = (SIGNED != 0) ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    p  = xe * ye;
    if (SIGNED != 0) return {{(SW-PW){p[PW-1]}}, p};
    else             return {{(SW-PW){1'b0}}, p};
  endfunction

  // Reduce an internal sum to an output word, wrapping or saturating.
  function automatic logic [WIDTH-1:0] fmt(input logic [SW-1:0] x);
    logic [WIDTH-1:0] r;
    r = x[WIDTH-1:0];
    if (SAT != 0) begin
      if (SIGNED != 0) begin
        if (x[SW-1:WIDTH-1] != {(SW-WIDTH+1){x[SW-1]}})
          r = x[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else if (x[SW-1:WIDTH] != '0) begin
        r = '1;
      end
    end
    return r;
  endfunction

  // Pick the operand pair for the lane currently being processed.
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k_q == KW'(i)) begin
        a_lane = a_q[i*WIDTH +: WIDTH];
        b_lane = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and datapath logic for the start/run/done sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mode_d  = mode_q;
    dot_d   = dot_q;
    acc_d   = acc_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    done_d  = 1'b0;
    acc_sum = acc_q + dot_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          a_d     = a_vec;
          b_d     = b_vec;
          c_d     = c;
          mode_d  = mode;
          dot_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dot_d = dot_q + lane_prod(a_lane, b_lane);
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        o2_d   = fmt(dot_q);
        case (mode_q)
          2'd1: begin
            acc_d = acc_sum;
            o1_d  = fmt(acc_sum);
          end
          2'd2: begin
            acc_d = '0;
            o1_d  = '0;
          end
          default: o1_d = fmt(ext_w(c_q) + dot_q);
        endcase
        if (ap_start) begin
          a_d     = a_vec;
          b_d     = b_vec;
          c_d     = c;
          mode_d  = mode;
          dot_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE);
  end

  // State, operand, accumulator and registered-output flops.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= '0;
      dot_q   <= '0;
      acc_q   <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      dot_q   <= dot_d;
      acc_q   <= acc_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  assign ap_done   = done_q;
  assign ap_ready  = done_q;
  assign o1_ap_vld = done_q;
  assign o2_ap_vld = done_q;
  assign ap_idle   = idle_q;
  assign o1        = o1_q;
  assign o2        = o2_q;

endmodule

// File: tb/tb_hls_macc_vec.sv
// Testbench for hls_macc_vec: three instances share stimulus (unsigned wrap,
// unsigned saturate, signed wrap) and each scenario task checks its results
// against hand-computed values.
module tb_hls_macc_vec;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int VW    = WIDTH * LANES;

  logic             clk;
  logic             rst_n;
  logic             ap_start;
  logic [1:0]       mode;
  logic [VW-1:0]    a_vec;
  logic [VW-1:0]    b_vec;
  logic [WIDTH-1:0] c;

  logic             u_done, u_idle, u_ready, u_o1_vld, u_o2_vld;
  logic [WIDTH-1:0] u_o1, u_o2;
  logic             t_done, t_idle, t_ready, t_o1_vld, t_o2_vld;
  logic [WIDTH-1:0] t_o1, t_o2;
  logic             s_done, s_idle, s_ready, s_o1_vld, s_o2_vld;
  logic [WIDTH-1:0] s_o1, s_o2;

  int errors;
  int checks;

  hls_macc_vec #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(0), .SAT(0)) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
    .ap_done(u_done), .ap_idle(u_idle), .ap_ready(u_ready),
    .mode(mode), .a_vec(a_vec), .b_vec(b_vec), .c(c),
    .o1(u_o1), .o1_ap_vld(u_o1_vld), .o2(u_o2), .o2_ap_vld(u_o2_vld)
  );

  hls_macc_vec #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(0), .SAT(1)) t_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
    .ap_done(t_done), .ap_idle(t_idle), .ap_ready(t_ready),
    .mode(mode), .a_vec(a_vec), .b_vec(b_vec), .c(c),
    .o1(t_o1), .o1_ap_vld(t_o1_vld), .o2(t_o2), .o2_ap_vld(t_o2_vld)
  );

  hls_macc_vec #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1), .SAT(0)) s_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
    .ap_done(s_done), .ap_idle(s_idle), .ap_ready(s_ready),
    .mode(mode), .a_vec(a_vec), .b_vec(b_vec), .c(c),
    .o1(s_o1), .o1_ap_vld(s_o1_vld), .o2(s_o2), .o2_ap_vld(s_o2_vld)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input logic [1:0] m,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3,
                         input logic [31:0] cc);
    mode  = m;
    a_vec = {a3, a2, a1, a0};
    b_vec = {b3, b2, b1, b0};
    c     = cc;
  endtask

  // Presents operands with a one-cycle start pulse; returns at the negedge after E0.
  task automatic start_txn(input logic [1:0] m,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input logic [31:0] cc);
    @(negedge clk);
    set_ops(m, a0, a1, a2, a3, b0, b1, b2, b3, cc);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  // Counts negedges until the done pulse is seen, giving up after 20.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (u_done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ap_start = 1'b0;
    set_ops(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (u_idle !== 1'b1 || t_idle !== 1'b1 || s_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b%b%b expected 111", u_idle, t_idle, s_idle);
    end
    checks++;
    if ({u_done, u_ready, u_o1_vld, u_o2_vld, t_done, t_ready, t_o1_vld, t_o2_vld,
         s_done, s_ready, s_o1_vld, s_o2_vld} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b%b%b%b expected 0000",
               u_done, u_ready, u_o1_vld, u_o2_vld);
    end
    checks++;
    if (u_o1 !== 32'h0 || u_o2 !== 32'h0 || t_o1 !== 32'h0 || s_o2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got o1=%h o2=%h expected 0 0", u_o1, u_o2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fresh();
    start_txn(2'd0, 1, 2, 3, 4, 5, 6, 7, 8, 10);
    checks++;
    if (u_idle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fresh_idle_n0: got %b expected 0", u_idle);
    end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (u_done !== 1'b0 || u_idle !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fresh_busy_n%0d: got done=%b idle=%b expected done=0 idle=0",
                 n, u_done, u_idle);
      end
    end
    @(negedge clk);
    checks++;
    if ({u_done, u_ready, u_o1_vld, u_o2_vld} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL fresh_strobes: got %b%b%b%b expected 1111",
               u_done, u_ready, u_o1_vld, u_o2_vld);
    end
    checks++;
    if (u_o2 !== 32'd70 || u_o1 !== 32'd80) begin
      errors++;
      $display("[TB] FAIL fresh_result: got o1=%0d o2=%0d expected o1=80 o2=70", u_o1, u_o2);
    end
    checks++;
    if (u_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fresh_idle_after: got %b expected 1", u_idle);
    end
    @(negedge clk);
    checks++;
    if (u_done !== 1'b0 || u_o1 !== 32'd80 || u_o2 !== 32'd70) begin
      errors++;
      $display("[TB] FAIL fresh_hold: got done=%b o1=%0d o2=%0d expected done=0 o1=80 o2=70",
               u_done, u_o1, u_o2);
    end
  endtask

  task automatic test_accumulate();
    logic [1:0]  modes [4];
    logic [31:0] exp_o1 [4];
    int cyc;
    modes  = '{2'd1, 2'd1, 2'd2, 2'd1};
    exp_o1 = '{32'd70, 32'd140, 32'd0, 32'd70};
    for (int i = 0; i < 4; i++) begin
      start_txn(modes[i], 1, 2, 3, 4, 5, 6, 7, 8, 10);
      wait_done(cyc);
      checks++;
      if (cyc != 5) begin
        errors++;
        $display("[TB] FAIL acc_latency_%0d: got %0d cycles expected 5", i, cyc);
      end
      checks++;
      if (u_o1 !== exp_o1[i] || u_o2 !== 32'd70) begin
        errors++;
        $display("[TB] FAIL acc_result_%0d: got o1=%0d o2=%0d expected o1=%0d o2=70",
                 i, u_o1, u_o2, exp_o1[i]);
      end
    end
  endtask

  task automatic test_wrap_sat();
    int cyc;
    start_txn(2'd0, 32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0, 0, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || u_o1 !== 32'hFFFF_FFFE || u_o2 !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL wrap_result: got cyc=%0d o1=%h o2=%h expected cyc=5 o1=fffffffe o2=fffffffe",
               cyc, u_o1, u_o2);
    end
    checks++;
    if (t_done !== 1'b1 || t_o1 !== 32'hFFFF_FFFF || t_o2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL sat_result: got done=%b o1=%h o2=%h expected done=1 o1=ffffffff o2=ffffffff",
               t_done, t_o1, t_o2);
    end
  endtask

  task automatic test_signed();
    int cyc;
    start_txn(2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 0,
                    32'd4, 32'hFFFF_FFFB, 0, 0, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++;
    if (s_done !== 1'b1 || s_o2 !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL signed_o2: got done=%b o2=%h expected done=1 o2=fffffffe", s_done, s_o2);
    end
    checks++;
    if (s_o1 !== 32'hFFFF_FFFD) begin
      errors++;
      $display("[TB] FAIL signed_o1: got %h expected fffffffd", s_o1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_o1 [3];
    logic [31:0] got_o2 [3];
    logic [31:0] exp_o1 [3];
    logic [31:0] exp_o2 [3];
    logic        exp_done;
    int nd;
    exp_o1 = '{32'd80, 32'd14, 32'd105};
    exp_o2 = '{32'd70, 32'd14, 32'd100};
    got_o1 = '{32'd0, 32'd0, 32'd0};
    got_o2 = '{32'd0, 32'd0, 32'd0};
    nd = 0;
    @(negedge clk);
    set_ops(2'd0, 1, 2, 3, 4, 5, 6, 7, 8, 10);
    ap_start = 1'b1;
    @(negedge clk);
    set_ops(2'd0, 1, 1, 1, 1, 2, 3, 4, 5, 0);
    checks++;
    if (u_idle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_n0: got %b expected 0", u_idle);
    end
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 5)  set_ops(2'd0, 10, 0, 0, 0, 10, 0, 0, 0, 5);
      if (n == 10) ap_start = 1'b0;
      exp_done = (n == 5 || n == 10 || n == 15);
      checks++;
      if (u_done !== exp_done) begin
        errors++;
        $display("[TB] FAIL b2b_done_n%0d: got %b expected %b", n, u_done, exp_done);
      end
      if (n <= 14) begin
        checks++;
        if (u_idle !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_idle_n%0d: got %b expected 0", n, u_idle);
        end
      end
      if (u_done === 1'b1) begin
        if (nd < 3) begin
          got_o1[nd] = u_o1;
          got_o2[nd] = u_o2;
        end
        nd++;
      end
    end
    checks++;
    if (nd != 3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d pulses expected 3", nd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_o1[i] !== exp_o1[i] || got_o2[i] !== exp_o2[i]) begin
        errors++;
        $display("[TB] FAIL b2b_result_%0d: got o1=%0d o2=%0d expected o1=%0d o2=%0d",
                 i, got_o1[i], got_o2[i], exp_o1[i], exp_o2[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int pulses;
    start_txn(2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_done(cyc);
    start_txn(2'd1, 1, 2, 3, 4, 5, 6, 7, 8, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || u_o1 !== 32'd70) begin
      errors++;
      $display("[TB] FAIL midrun_preload: got cyc=%0d o1=%0d expected cyc=5 o1=70", cyc, u_o1);
    end
    start_txn(2'd1, 2, 2, 0, 0, 3, 3, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_idle !== 1'b1 || u_o1 !== 32'd0 || u_o2 !== 32'd0 ||
        {u_done, u_ready, u_o1_vld, u_o2_vld} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got idle=%b o1=%0d o2=%0d strobes=%b%b%b%b expected idle=1 o1=0 o2=0 strobes=0000",
               u_idle, u_o1, u_o2, u_done, u_ready, u_o1_vld, u_o2_vld);
    end
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      if (u_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: got %0d pulses expected 0", pulses);
    end
    start_txn(2'd1, 2, 2, 0, 0, 3, 3, 0, 0, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || u_o1 !== 32'd12 || u_o2 !== 32'd12) begin
      errors++;
      $display("[TB] FAIL midrun_acc_cleared: got cyc=%0d o1=%0d o2=%0d expected cyc=5 o1=12 o2=12",
               cyc, u_o1, u_o2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fresh();
    test_accumulate();
    test_wrap_sat();
    test_signed();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
